mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//   Shares the single-port unified instruction/data RAM between instruction fetch and the execute
//   stage's load/store port. Grants one requester per free cycle and tracks read latency.
//   Routes read data back to the owner and raises a pipeline stall while a data access is blocked or pending.
//   Sits between fetch, inst_execute and the RAM wrapper.
// PARAMETERS
//   RD_LATENCY    2   cycles from ram_en (read) to valid ram_dout; legal 1..3
//   STARVE_LIMIT  4   consecutive denied fetch cycles before fetch is forced to win (guard only)
// PORTS
//   clk        in   1   clock, rising edge
//   rst        in   1   reset, asynchronous, active-high
//   if_req     in   1   fetch read request; held until if_gnt
//   if_addr    in   30  fetch word address [31:2]
//   if_gnt     out  1   fetch request accepted this cycle
//   if_rvalid  out  1   if_rdata valid this cycle
//   if_rdata   out  32  fetched word
//   d_en       in   1   data access request; held until d_gnt
//   d_we       in   1   1 = store, 0 = load
//   d_addr     in   30  data word address [31:2]
//   d_din      in   32  store data
//   d_gnt      out  1   data request accepted this cycle
//   d_rvalid   out  1   d_rdata valid this cycle
//   d_rdata    out  32  load data
//   ram_en     out  1   RAM access strobe
//   ram_we     out  1   RAM write enable
//   ram_addr   out  30  RAM word address
//   ram_din    out  32  RAM write data
//   ram_dout   in   32  RAM read data, valid RD_LATENCY cycles after read strobe
//   stall      out  1   freeze fetch/decode/execute this cycle
// BEHAVIOUR
//   - State: cnt (2 bits, read countdown), owner (0 fetch / 1 data), starve (3 bits).
//   - free = (cnt <= 1). Grant is combinational and only when free; at most one grant per cycle.
//   - Priority: d_en beats if_req. Loser sees gnt = 0 and must hold its request unchanged.
//   - Granted read: ram_en = 1, ram_we = 0, ram_addr = winner addr; cnt <= RD_LATENCY; owner <= winner.
//   - Granted store: ram_en = 1, ram_we = 1, ram_addr = d_addr, ram_din = d_din.
//     Completes in the grant cycle; cnt unchanged by the store; no rvalid.
//   - Otherwise cnt decrements toward 0 each cycle.
//   - Return: when cnt == 1, the owner's rvalid = 1 and its rdata = ram_dout.
//     Non-owner rdata = 0; rdata = 0 whenever rvalid = 0.
//   - Back-to-back: a new grant is allowed in the same cycle as the rvalid (cnt == 1).
//     Read throughput: 1 per RD_LATENCY cycles.
//   - No grant: ram_en = ram_we = 0, ram_addr = 0, ram_din = 0.
//   - ram_din = 0 on every non-store cycle.
//   - stall = (d_en & ~d_gnt) | (data read pending & ~d_rvalid).
//     A load is stalled from its grant until the d_rvalid cycle inclusive-exclusive:
//     stall is 0 in the d_rvalid cycle.
//   - Simultaneous if_req and d_en while not free: both denied; stall = 1.
//   - Reset (any time, including mid-read):
//     - cnt = 0, owner = 0, starve = 0.
//     - All gnt, rvalid, ram_en, ram_we and stall = 0; all data/addr outputs = 0.
//     - A read in flight at reset never produces rvalid.
//   - RD_LATENCY outside 1..3: elaboration error.
// CONFIGURATION
//   STARVE_GUARD_EN defined:
//     - starve increments (saturating at STARVE_LIMIT) each cycle if_req = 1 and if_gnt = 0.
//     - starve clears on if_gnt or when if_req = 0.
//     - When starve == STARVE_LIMIT, fetch beats d_en at the next free cycle; stall = 1 that cycle.
//   STARVE_GUARD_EN undefined:
//     - Strict data priority; starve register absent; fetch may wait indefinitely.
// TESTING (RD_LATENCY = 2)
//   1. Reset, then if_req with if_addr = 0x100 -> if_gnt @t, ram_addr = 0x100;
//      ram_dout = 0xDEADBEEF @t+2 -> if_rvalid @t+2, if_rdata = 0xDEADBEEF.
//   2. if_req and d_en load, same cycle -> d_gnt = 1, if_gnt = 0; stall = 1 @t and @t+1;
//      d_rvalid @t+2 with stall = 0; if_gnt @t+2.
//   3. Store d_addr = 0x40, d_din = 0x12345678 while free -> ram_we = 1 same cycle;
//      no rvalid; stall = 0.
//   4. Load granted @t, store requested @t+1 -> store denied, stall = 1;
//      store granted @t+2 with d_rvalid for the load.
//   5. Assert rst @t+1 during a fetch read granted @t -> no if_rvalid @t+2; all outputs 0.
//   6. STARVE_GUARD_EN: continuous d_en loads plus if_req -> fetch wins the first free cycle
//      after 4 denied cycles; without the macro fetch is never granted.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//   Shares the single-port unified instruction/data RAM between instruction
//   fetch and the execute stage's load/store port. At most one requester is
//   granted per free cycle (data beats fetch). Read latency is tracked with a
//   small countdown so read data is routed back to its owner, and a pipeline
//   stall is raised while a data access is blocked or a load is pending.
//
// Parameters
//   RD_LATENCY    cycles from a read strobe to valid ram_dout (1..3)
//   STARVE_LIMIT  consecutive denied fetch cycles before fetch is forced to
//                 win (used only with STARVE_GUARD_EN; 1..7)
//
// Configuration macro
//   STARVE_GUARD_EN  defined   : fetch starvation guard present
//                    undefined : strict data priority, no starve register
//
// Ports
//   clk, rst                         clock (rising edge), async active-high reset
//   if_req/if_addr -> if_gnt         fetch read request / accept
//   if_rvalid/if_rdata               fetched word return
//   d_en/d_we/d_addr/d_din -> d_gnt  data load/store request / accept
//   d_rvalid/d_rdata                 load data return
//   ram_en/ram_we/ram_addr/ram_din   RAM strobe, write enable, address, data
//   ram_dout                         RAM read data
//   stall                            freeze fetch/decode/execute this cycle
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int unsigned RD_LATENCY   = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [29:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_en,
  input  logic        d_we,
  input  logic [29:0] d_addr,
  input  logic [31:0] d_din,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        ram_en,
  output logic        ram_we,
  output logic [29:0] ram_addr,
  output logic [31:0] ram_din,
  input  logic [31:0] ram_dout,
  output logic        stall
);

  if (RD_LATENCY < 1 || RD_LATENCY > 3) begin : g_bad_latency
    $error("mem_port_arbiter: RD_LATENCY must be in 1..3");
  end

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 7) begin : g_bad_starve
    $error("mem_port_arbiter: STARVE_LIMIT must be in 1..7");
  end

  localparam logic [1:0] LAT = 2'(RD_LATENCY);

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_DATA  = 1'b1
  } owner_e;

  logic [1:0] cnt_q, cnt_d;
  owner_e     owner_q, owner_d;
  logic       free;
  logic       ret;
  logic       fetch_first;

  // cnt == 1 is the return cycle; a new grant may overlap it.
  assign free = (cnt_q <= 2'd1);
  assign ret  = (cnt_q == 2'd1);

`ifdef STARVE_GUARD_EN
  localparam logic [2:0] STARVE_MAX = 3'(STARVE_LIMIT);
  logic [2:0] starve_q, starve_d;

  assign fetch_first = (starve_q == STARVE_MAX);

  always_comb begin
    starve_d = '0;
    if (if_req && !if_gnt) begin
      starve_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + 3'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) starve_q <= '0;
    else     starve_q <= starve_d;
  end
`else
  assign fetch_first = 1'b0;
`endif

  // Grant and RAM drive
  always_comb begin
    if_gnt   = 1'b0;
    d_gnt    = 1'b0;
    ram_en   = 1'b0;
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_din  = '0;
    if (!rst && free) begin
      if (if_req && (fetch_first || !d_en)) begin
        if_gnt   = 1'b1;
        ram_en   = 1'b1;
        ram_addr = if_addr;
      end else if (d_en) begin
        d_gnt    = 1'b1;
        ram_en   = 1'b1;
        ram_we   = d_we;
        ram_addr = d_addr;
        ram_din  = d_we ? d_din : '0;
      end
    end
  end

  // Read return routing and stall
  always_comb begin
    if_rvalid = !rst && ret && (owner_q == OWN_FETCH);
    d_rvalid  = !rst && ret && (owner_q == OWN_DATA);
    if_rdata  = if_rvalid ? ram_dout : '0;
    d_rdata   = d_rvalid  ? ram_dout : '0;
    // A load stalls from its grant cycle up to, but not including, its
    // return cycle; a blocked data request stalls as well.
    stall = !rst && ((d_en && !d_gnt) ||
                     (d_gnt && !d_we) ||
                     ((owner_q == OWN_DATA) && (cnt_q >= 2'd2)));
  end

  // Latency countdown and owner tracking; stores leave the countdown alone.
  always_comb begin
    cnt_d   = (cnt_q == 2'd0) ? 2'd0 : cnt_q - 2'd1;
    owner_d = owner_q;
    if (if_gnt) begin
      cnt_d   = LAT;
      owner_d = OWN_FETCH;
    end else if (d_gnt && !d_we) begin
      cnt_d   = LAT;
      owner_d = OWN_DATA;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      owner_q <= OWN_FETCH;
    end else begin
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  localparam int RDL  = 2;
  localparam int SLIM = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_gnt, if_rvalid;
  logic [29:0] if_addr;
  logic [31:0] if_rdata;
  logic        d_en, d_we, d_gnt, d_rvalid;
  logic [29:0] d_addr;
  logic [31:0] d_din, d_rdata;
  logic        ram_en, ram_we;
  logic [29:0] ram_addr;
  logic [31:0] ram_din, ram_dout;
  logic        stall;

  mem_port_arbiter #(.RD_LATENCY(RDL), .STARVE_LIMIT(SLIM)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_en(d_en), .d_we(d_we), .d_addr(d_addr), .d_din(d_din),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout), .stall(stall)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
    end
  endtask

  // RAM emulation (responds to DUT strobes)
  logic [31:0] r_mem [16];
  logic        r_valid [8];
  logic [31:0] r_val [8];

  // Reference model: cycle-numbered return schedule
  int          cyc = 0;
  int          m_ret = -1;      // cycle in which the pending read returns
  bit          m_ret_data = 0;  // pending read belongs to data port
  logic [31:0] m_ret_val;
  int          m_starve = 0;
  logic [31:0] m_mem [16];
  bit          last_if_gnt, last_d_gnt;

  task automatic step(input logic fr, input logic [29:0] fa, input logic de,
                      input logic dw, input logic [29:0] da, input logic [31:0] dd);
    bit free, ff, eg_if, eg_d, ev_if, ev_d, e_stall;
    int ps, slot;
    @(negedge clk);
    if_req = fr; if_addr = fa; d_en = de; d_we = dw; d_addr = da; d_din = dd;
    ps = (cyc + 8 - RDL) % 8;
    ram_dout = r_valid[ps] ? r_val[ps] : $urandom;
    #1;
    free = (cyc >= m_ret);
    ff = 1'b0;
`ifdef STARVE_GUARD_EN
    ff = (m_starve >= SLIM);
`endif
    eg_if   = free && fr && (ff || !de);
    eg_d    = free && de && !eg_if;
    ev_if   = (m_ret == cyc) && !m_ret_data;
    ev_d    = (m_ret == cyc) && m_ret_data;
    e_stall = (de && !eg_d) || (eg_d && !dw) || (m_ret_data && m_ret > cyc);

    check_eq("if_gnt",    32'(if_gnt),    32'(eg_if));
    check_eq("d_gnt",     32'(d_gnt),     32'(eg_d));
    check_eq("if_rvalid", 32'(if_rvalid), 32'(ev_if));
    check_eq("if_rdata",  if_rdata,       ev_if ? m_ret_val : 32'd0);
    check_eq("d_rvalid",  32'(d_rvalid),  32'(ev_d));
    check_eq("d_rdata",   d_rdata,        ev_d ? m_ret_val : 32'd0);
    check_eq("ram_en",    32'(ram_en),    32'(eg_if || eg_d));
    check_eq("ram_we",    32'(ram_we),    32'(eg_d && dw));
    check_eq("ram_addr",  32'(ram_addr),  eg_if ? 32'(fa) : (eg_d ? 32'(da) : 32'd0));
    check_eq("ram_din",   ram_din,        (eg_d && dw) ? dd : 32'd0);
    check_eq("stall",     32'(stall),     32'(e_stall));

    slot = cyc % 8;
    r_valid[slot] = ram_en && !ram_we;
    r_val[slot]   = r_mem[ram_addr[3:0]];
    if (ram_en && ram_we) r_mem[ram_addr[3:0]] = ram_din;

    if (eg_if) begin
      m_ret = cyc + RDL; m_ret_data = 1'b0; m_ret_val = m_mem[fa[3:0]];
    end else if (eg_d) begin
      if (dw) m_mem[da[3:0]] = dd;
      else begin m_ret = cyc + RDL; m_ret_data = 1'b1; m_ret_val = m_mem[da[3:0]]; end
    end
    if (fr && !eg_if) m_starve = (m_starve >= SLIM) ? SLIM : m_starve + 1;
    else              m_starve = 0;
    last_if_gnt = eg_if;
    last_d_gnt  = eg_d;
    cyc++;
  endtask

  // One cycle in reset with live requests; all outputs must be quiet.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    if_req = 1'b1; if_addr = 30'($urandom); d_en = 1'b1; d_we = 1'($urandom);
    d_addr = 30'($urandom); d_din = $urandom; ram_dout = $urandom;
    #1;
    check_eq("rst_if_gnt",    32'(if_gnt),    32'd0);
    check_eq("rst_d_gnt",     32'(d_gnt),     32'd0);
    check_eq("rst_if_rvalid", 32'(if_rvalid), 32'd0);
    check_eq("rst_if_rdata",  if_rdata,       32'd0);
    check_eq("rst_d_rvalid",  32'(d_rvalid),  32'd0);
    check_eq("rst_d_rdata",   d_rdata,        32'd0);
    check_eq("rst_ram_en",    32'(ram_en),    32'd0);
    check_eq("rst_ram_we",    32'(ram_we),    32'd0);
    check_eq("rst_ram_addr",  32'(ram_addr),  32'd0);
    check_eq("rst_ram_din",   ram_din,        32'd0);
    check_eq("rst_stall",     32'(stall),     32'd0);
    r_valid[cyc % 8] = 1'b0;
    m_ret = -1; m_ret_data = 1'b0; m_starve = 0;
    cyc++;
    #1;
    if_req = 1'b0; d_en = 1'b0;
    rst = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  bit          f_req = 0, dq_req = 0, dq_we = 0;
  logic [29:0] f_addr, dq_addr;
  logic [31:0] dq_din;
  int unsigned n_fg;

  initial begin
    rst = 1'b1;
    if_req = 1'b0; if_addr = '0; d_en = 1'b0; d_we = 1'b0; d_addr = '0; d_din = '0;
    ram_dout = '0;
    for (int i = 0; i < 16; i++) begin
      r_mem[i] = 32'h1000_0000 + 32'(i) * 32'h0101_0101;
      m_mem[i] = r_mem[i];
    end
    for (int i = 0; i < 8; i++) begin r_valid[i] = 1'b0; r_val[i] = '0; end
    r_mem[0] = 32'hDEAD_BEEF; m_mem[0] = 32'hDEAD_BEEF;
    do_reset();

    // fetch read of 0x100 returning 0xDEADBEEF
    step(1'b1, 30'h100, 1'b0, 1'b0, '0, '0);
    idle(3);
    // simultaneous fetch and load: load wins, fetch follows in the return cycle
    step(1'b1, 30'h104, 1'b1, 1'b0, 30'h22, '0);
    step(1'b1, 30'h104, 1'b0, 1'b0, '0, '0);
    step(1'b1, 30'h104, 1'b0, 1'b0, '0, '0);
    idle(3);
    // store while free
    step(1'b0, '0, 1'b1, 1'b1, 30'h40, 32'h1234_5678);
    idle(1);
    // load then store: store blocked until the load's return cycle
    step(1'b0, '0, 1'b1, 1'b0, 30'h40, '0);
    step(1'b0, '0, 1'b1, 1'b1, 30'h43, 32'hCAFE_F00D);
    step(1'b0, '0, 1'b1, 1'b1, 30'h43, 32'hCAFE_F00D);
    idle(3);
    // reset during a fetch read in flight
    step(1'b1, 30'h7, 1'b0, 1'b0, '0, '0);
    do_reset();
    idle(3);
    // continuous loads against a waiting fetch
    n_fg = 0;
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 30'h55, 1'b1, 1'b0, 30'(i), '0);
      if (last_if_gnt) n_fg++;
    end
`ifdef STARVE_GUARD_EN
    check_eq("starve_fetch_grants", n_fg, 32'd2);
`else
    check_eq("starve_fetch_grants", n_fg, 32'd0);
`endif
    idle(3);

    // randomized traffic; requesters hold until granted
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      if (!f_req) begin
        f_req = ($urandom_range(0, 2) != 0); f_addr = 30'($urandom);
      end
      if (!dq_req) begin
        dq_req = ($urandom_range(0, 1) != 0); dq_we = 1'($urandom);
        dq_addr = 30'($urandom); dq_din = $urandom;
      end
      step(f_req, f_addr, dq_req, dq_we, dq_addr, dq_din);
      if (last_if_gnt) f_req = 0;
      if (last_d_gnt)  dq_req = 0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
